// File: rtl/packet_tx_arbiter_if.sv
// Packet source / TX path handshake bundle for packet_tx_arbiter.
// The slave side is the arbiter. The master side is the environment
// (source FIFOs plus the downstream TX FIFO).
interface packet_tx_arbiter_if #(
    parameter int NUM_SOURCES = 2,
    parameter int WORD_SIZE   = 64
);
    logic [NUM_SOURCES-1:0]           in_nempty;
    logic [NUM_SOURCES-1:0]           in_pop;
    logic [NUM_SOURCES*WORD_SIZE-1:0] in_data;
    logic [NUM_SOURCES-1:0]           in_end;
    logic                             out_pop;
    logic                             out_nempty;
    logic [WORD_SIZE-1:0]             out_data;
    logic                             out_end;

    modport master (
        output in_nempty, in_data, in_end, out_pop,
        input  in_pop, out_nempty, out_data, out_end
    );

    modport slave (
        input  in_nempty, in_data, in_end, out_pop,
        output in_pop, out_nempty, out_data, out_end
    );
endinterface

// File: rtl/packet_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one TX packet path.
// A packet is never interleaved with another one. A word-count watchdog
// force-ends any packet longer than MAX_PACKET_WORDS. The leftover words
// of that source then compete again as a fresh packet.
module packet_tx_arbiter #(
    parameter int NUM_SOURCES      = 2,
    parameter int WORD_SIZE        = 64,
    parameter int MAX_PACKET_WORDS = 4096,
    parameter int GRANT_BITS       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    packet_tx_arbiter_if.slave    bus,
    output logic [GRANT_BITS-1:0] grant,
    output logic                  busy,
    output logic [15:0]           trunc_count
);
    // Counter only needs to reach MAX_PACKET_WORDS-1.
    localparam int CNT_W = (MAX_PACKET_WORDS > 2) ? $clog2(MAX_PACKET_WORDS) : 1;
    localparam logic [CNT_W-1:0]      CNT_LIMIT = CNT_W'(MAX_PACKET_WORDS - 1);
    localparam logic [GRANT_BITS-1:0] GRANT_RST = GRANT_BITS'(NUM_SOURCES - 1);

    typedef enum logic {IDLE, PASS} state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic                   pick_vld;
    logic [GRANT_BITS-1:0]  pick_idx;
    logic                   cur_nempty;
    logic                   cur_end;
    logic [WORD_SIZE-1:0]   cur_data;
    logic                   can_load;
    logic                   load;
    logic                   at_limit;
    logic                   pkt_last;

    // Round-robin pick: the first requester after grant, with grant itself last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = grant;
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            for (int j = 0; j < NUM_SOURCES; j++) begin
                if (!pick_vld && bus.in_nempty[j] &&
                    (j == (int'(grant) + k) % NUM_SOURCES)) begin
                    pick_vld = 1'b1;
                    pick_idx = GRANT_BITS'(j);
                end
            end
        end
    end

    // Mux the granted source's FIFO head.
    always_comb begin
        cur_nempty = 1'b0;
        cur_end    = 1'b0;
        cur_data   = '0;
        for (int j = 0; j < NUM_SOURCES; j++) begin
            if (grant == GRANT_BITS'(j)) begin
                cur_nempty = bus.in_nempty[j];
                cur_end    = bus.in_end[j];
                cur_data   = bus.in_data[j*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // Transfer qualifiers. The output register can take a word when it is
    // empty or is being drained in the same cycle.
    always_comb begin
        can_load = !bus.out_nempty || bus.out_pop;
        load     = (state == PASS) && cur_nempty && can_load;
        at_limit = (cnt == CNT_LIMIT);
        pkt_last = cur_end || at_limit;
        for (int j = 0; j < NUM_SOURCES; j++)
            bus.in_pop[j] = load && (grant == GRANT_BITS'(j));
    end

    // Next-state logic: arbitrate in IDLE, stay in PASS until the packet ends.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_vld) state_nxt = PASS;
            PASS: if (load && pkt_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant and per-packet word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= GRANT_RST;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_vld) begin
                grant <= pick_idx;
                cnt   <= '0;
            end else if (load) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Single-entry output register with FIFO semantics.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_nempty <= 1'b0;
            bus.out_data   <= '0;
            bus.out_end    <= 1'b0;
        end else if (load) begin
            bus.out_nempty <= 1'b1;
            bus.out_data   <= cur_data;
            bus.out_end    <= pkt_last;
        end else if (bus.out_pop) begin
            bus.out_nempty <= 1'b0;
        end
    end

    // Count packets cut by the watchdog. The count saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            trunc_count <= '0;
        else if (load && at_limit && !cur_end && trunc_count != 16'hFFFF)
            trunc_count <= trunc_count + 16'd1;
    end

    assign busy = (state == PASS);

endmodule

// File: tb/tb_packet_tx_arbiter.sv
// Scoreboard bench for packet_tx_arbiter. A packet-level round-robin model
// predicts the output word stream. A negedge monitor pops the prediction
// queue and compares it with every word that leaves the output register.
module tb_packet_tx_arbiter;
    localparam int NS   = 2;
    localparam int W    = 64;
    localparam int MAXW = 4;
    localparam int GB   = 3;

    typedef struct {
        logic [W-1:0] d;
        logic         e;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [GB-1:0] grant;
    logic          busy;
    logic [15:0]   trunc_count;

    always #5 clk = ~clk;

    packet_tx_arbiter_if #(.NUM_SOURCES(NS), .WORD_SIZE(W)) bus ();

    packet_tx_arbiter #(
        .NUM_SOURCES(NS), .WORD_SIZE(W), .MAX_PACKET_WORDS(MAXW), .GRANT_BITS(GB)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .grant(grant), .busy(busy),
        .trunc_count(trunc_count)
    );

    word_t   src_q[NS][$];
    word_t   exp_q[$];
    int      errors = 0;
    int      checks = 0;
    int      m_rr = NS - 1;
    int      exp_trunc = 0;
    int      seq = 0;
    logic [NS-1:0] pop_s = '0;
    logic [NS-1:0] stall = '0;
    bit      bp_en = 0;
    bit      stall_en = 0;
    int      hold = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level reference: visit sources round-robin starting after the
    // last winner. Each visit emits one packet, which ends on its end flag
    // or at the MAXW-th word.
    function automatic void predict();
        word_t cp[NS][$];
        int    s;
        int    c;
        bit    found;
        bit    last;
        word_t w;
        for (int i = 0; i < NS; i++) cp[i] = src_q[i];
        forever begin
            found = 0;
            s = m_rr;
            for (int k = 1; k <= NS; k++) begin
                if (!found && cp[(m_rr + k) % NS].size() > 0) begin
                    found = 1;
                    s = (m_rr + k) % NS;
                end
            end
            if (!found) break;
            c = 0;
            forever begin
                w = cp[s].pop_front();
                last = w.e || (c == MAXW - 1);
                exp_q.push_back('{d: w.d, e: last});
                if (last && !w.e) exp_trunc++;
                if (last) break;
                c++;
            end
            m_rr = s;
        end
    endfunction

    task automatic push_pkt(input int src, input int len);
        for (int k = 0; k < len; k++) begin
            seq++;
            src_q[src].push_back('{d: (64'(src) << 56) | 64'(seq), e: (k == len - 1)});
        end
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < NS; i++) begin
            bus.in_nempty[i] = (src_q[i].size() > 0) && !stall[i];
            if (src_q[i].size() > 0) begin
                bus.in_data[i*W +: W] = src_q[i][0].d;
                bus.in_end[i]         = src_q[i][0].e;
            end else begin
                bus.in_data[i*W +: W] = '0;
                bus.in_end[i]         = 1'b0;
            end
        end
    endtask

    // One clock: retire the pops seen last cycle, then redraw backpressure
    // and stalls. A source may only stall while it holds the grant in PASS.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++)
            if (pop_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        for (int i = 0; i < NS; i++)
            stall[i] = stall_en && busy && (grant == GB'(i)) && ($urandom_range(2) == 0);
        if (hold > 0) hold--;
        else if (bp_en && $urandom_range(15) == 0) hold = 5;
        bus.out_pop = (hold > 0) ? 1'b0 : (bp_en ? ($urandom_range(2) != 0) : 1'b1);
        drive_srcs();
    endtask

    task automatic drain(input string name);
        bit done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            if (exp_q.size() == 0 && !busy && !bus.out_nempty &&
                src_q[0].size() == 0 && src_q[1].size() == 0)
                done = 1;
            else
                step();
        end
        chk({name, "_drained"}, 64'(done), 64'd1);
        chk({name, "_trunc"}, 64'(trunc_count), 64'(exp_trunc));
    endtask

    // Record pops where signals are stable; they are applied after the edge.
    always @(negedge clk) pop_s <= bus.in_pop;

    // Monitor: every word leaving the output register must match the model.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (bus.out_nempty && bus.out_pop) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", bus.out_data, 64'hx);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    chk("out_data", bus.out_data, e.d);
                    chk("out_end", 64'(bus.out_end), 64'(e.e));
                end
            end
            chk("in_pop_onehot", 64'($countones(bus.in_pop) <= 1), 64'd1);
            chk("in_pop_idle", 64'(!busy && bus.in_pop != '0), 64'd0);
        end
    end

    initial begin
        rst = 1'b1;
        bus.out_pop = 1'b0;
        bus.in_nempty = '0;
        bus.in_data = '0;
        bus.in_end = '0;
        step();
        step();
        chk("rst_out_nempty", 64'(bus.out_nempty), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant), 64'(NS - 1));
        chk("rst_trunc", 64'(trunc_count), 64'd0);
        chk("rst_in_pop", 64'(bus.in_pop), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        rst = 1'b0;
        step();

        // Single 3-word packet on source 0 with a free-running sink.
        push_pkt(0, 3);
        predict();
        drive_srcs();
        drain("single");
        chk("single_grant", 64'(grant), 64'd0);

        // Two 2-word packets per source: the sources alternate, starting
        // after the last winner (source 0), so source 1 goes first.
        push_pkt(0, 2); push_pkt(0, 2);
        push_pkt(1, 2); push_pkt(1, 2);
        predict();
        drive_srcs();
        drain("alternate");

        // Watchdog: a 6-word packet is split into 4 + 2 words.
        push_pkt(1, 6);
        predict();
        drive_srcs();
        drain("watchdog");
        chk("watchdog_count", 64'(trunc_count), 64'd1);

        // Random batches with backpressure and mid-packet starvation.
        bp_en = 1;
        stall_en = 1;
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < NS; i++) begin
                int np;
                np = $urandom_range(3);
                for (int p = 0; p < np; p++) push_pkt(i, $urandom_range(1, 7));
            end
            predict();
            drive_srcs();
            drain("random");
        end

        // Reset while the 2nd word of a packet is being popped.
        bp_en = 0;
        stall_en = 0;
        step();
        push_pkt(0, 4);
        push_pkt(1, 2);
        predict();
        drive_srcs();
        for (int c = 0; c < 20 && !bus.out_nempty; c++) step();
        rst = 1'b1;
        step();
        chk("mid_rst_out_nempty", 64'(bus.out_nempty), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_grant", 64'(grant), 64'(NS - 1));
        chk("mid_rst_trunc", 64'(trunc_count), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        m_rr = NS - 1;
        exp_trunc = 0;
        predict();
        drive_srcs();
        step();
        chk("post_rst_grant", 64'(grant), 64'd0);
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
